// File: rtl/blink_led.sv
// -----------------------------------------------------------------------------
// blink_led
//
// Free-running LED blinker. A terminal-count counter divides clk down, and a
// registered LED output toggles each time the counter wraps. The result is a
// square wave at BLINK_HZ with a 50% duty cycle. The first toggle happens on
// the HALF-th rising edge after reset is released, and the full period is
// exactly 2*HALF clocks.
//
// Parameters:
//   CLK_HZ       input clock frequency in Hz
//   BLINK_HZ     LED blink frequency in Hz (one on phase plus one off phase)
//   LED_ON_LEVEL pin level that lights the LED (1 = active-high, 0 = active-low)
//
// Ports:
//   clk     in   system clock; all state updates on the rising edge
//   resetb  in   asynchronous active-low reset; clears all state immediately
//   led     out  LED pin drive, taken directly from a flip-flop
// -----------------------------------------------------------------------------
module blink_led #(
  parameter int unsigned CLK_HZ       = 32_000_000,
  parameter int unsigned BLINK_HZ     = 1,
  parameter bit          LED_ON_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic resetb,
  output logic led
);

  // Clocks per half period, using integer division. This is not overridable.
  localparam int unsigned HALF = CLK_HZ / (2 * BLINK_HZ);

  // Counter width. When HALF is 1, the counter only ever holds 0, but it still
  // needs at least one bit.
  localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;

  // Terminal count. The counter wraps to zero after reaching this value, so it
  // never exceeds HALF-1 and never overflows its width.
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  // Pin level that keeps the LED dark. The pin shows this level during reset.
  localparam logic OFF_LEVEL = ~LED_ON_LEVEL;

  // A blink rate above clk/2 gives HALF == 0 and has no meaningful divider.
  // Reject that case while the design is being built, not in silicon.
  if (HALF == 0) begin : g_bad_divide
    $error("blink_led: BLINK_HZ (%0d) must not exceed CLK_HZ/2 (CLK_HZ=%0d)",
           BLINK_HZ, CLK_HZ);
  end

  logic [CW-1:0] cnt;
  logic          cnt_wrap;

  // led_q holds the LED state already mapped to pin polarity. In other words,
  // led_q == led_state ^ ~LED_ON_LEVEL. Because the mapping is applied inside
  // the flip-flop, the pin is driven straight from a register and no
  // inverter sits after it.
  logic          led_q;

  assign cnt_wrap = (cnt == LAST);

  // NOTE: sequential state is updated with non-blocking assignments. Every
  // flop then samples the pre-edge values, whatever order the statements
  // are written in.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt   <= '0;
      led_q <= OFF_LEVEL;
    end else if (cnt_wrap) begin
      cnt   <= '0;
      led_q <= ~led_q;
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_blink_led.sv
// -----------------------------------------------------------------------------
// tb_blink_led
//
// Self-checking bench for blink_led. Several small-divide instances share one
// clock and one reset:
//   u_a  HALF=5, active-high     (CLK_HZ=10, BLINK_HZ=1)
//   u_b  HALF=5, active-low      (CLK_HZ=10, BLINK_HZ=1, LED_ON_LEVEL=0)
//   u_c  HALF=1, active-high     (CLK_HZ=2,  BLINK_HZ=1)
//   u_d  HALF=3, active-high     (CLK_HZ=15, BLINK_HZ=2 -> integer division)
//   u_e  HALF=4, active-high     (CLK_HZ=8,  BLINK_HZ=1 -> power-of-two HALF)
//
// Model: n is the number of rising edges seen with reset high since the last
// reset. The lit state is then ((n / HALF) mod 2), and the pin level is that
// value mapped through LED_ON_LEVEL.
// -----------------------------------------------------------------------------
module tb_blink_led;

  logic clk = 1'b0;
  logic resetb;
  logic led_a, led_b, led_c, led_d, led_e;

  always #5 clk = ~clk;

  blink_led #(.CLK_HZ(10), .BLINK_HZ(1), .LED_ON_LEVEL(1'b1)) u_a (
    .clk(clk), .resetb(resetb), .led(led_a));
  blink_led #(.CLK_HZ(10), .BLINK_HZ(1), .LED_ON_LEVEL(1'b0)) u_b (
    .clk(clk), .resetb(resetb), .led(led_b));
  blink_led #(.CLK_HZ(2),  .BLINK_HZ(1), .LED_ON_LEVEL(1'b1)) u_c (
    .clk(clk), .resetb(resetb), .led(led_c));
  blink_led #(.CLK_HZ(15), .BLINK_HZ(2), .LED_ON_LEVEL(1'b1)) u_d (
    .clk(clk), .resetb(resetb), .led(led_d));
  blink_led #(.CLK_HZ(8),  .BLINK_HZ(1), .LED_ON_LEVEL(1'b1)) u_e (
    .clk(clk), .resetb(resetb), .led(led_e));

  int vectors     = 0;
  int miscompares = 0;
  int n           = 0;
  bit live        = 1'b0;

  // Expected LED pins for edges 1..14 after a release (hand-computed).
  int exp_a [14] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
  int exp_c [14] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};

  task automatic check(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  function automatic logic model_pin(input int half, input bit on_level,
                                     input int edges);
    logic lit;
    lit = ((edges / half) % 2) == 1;
    return on_level ? lit : ~lit;
  endfunction

  // Count rising edges since the last reset.
  always @(posedge clk or negedge resetb) begin
    if (!resetb) n <= 0;
    else         n <= n + 1;
  end

  // Compare every instance against the model, away from the active edge.
  always @(negedge clk) begin
    if (live) begin
      check("model_a", led_a, model_pin(5, 1'b1, n));
      check("model_b", led_b, model_pin(5, 1'b0, n));
      check("model_c", led_c, model_pin(1, 1'b1, n));
      check("model_d", led_d, model_pin(3, 1'b1, n));
      check("model_e", led_e, model_pin(4, 1'b1, n));
    end
  end

  task automatic release_reset();
    @(negedge clk);
    #1 resetb = 1'b1;
  endtask

  // Check the literal sequence for edges 1..count after a release.
  task automatic literal_edges(input int count);
    for (int i = 0; i < count; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("lit_a_e%0d", i + 1), led_a, exp_a[i] != 0);
      check($sformatf("lit_b_e%0d", i + 1), led_b, exp_a[i] == 0);
      check($sformatf("lit_c_e%0d", i + 1), led_c, exp_c[i] != 0);
      check($sformatf("pin_model_e%0d", i + 1), model_pin(5, 1'b1, n),
            exp_a[i] != 0);
    end
  endtask

  initial begin
    resetb = 1'b0;
    live   = 1'b1;

    // Reset hold: roughly 100 ns. Every pin must stay at its off level.
    repeat (5) @(posedge clk);
    #1;
    check("rst_a", led_a, 1'b0);
    check("rst_b", led_b, 1'b1);
    check("rst_c", led_c, 1'b0);
    repeat (5) @(posedge clk);

    // First run from release.
    release_reset();
    literal_edges(14);

    // Mid-operation reset, asserted between edges 7 and 8 while u_a is lit.
    @(negedge clk);
    #1 resetb = 1'b0;
    repeat (3) @(posedge clk);
    release_reset();
    literal_edges(7);
    #2 resetb = 1'b0;
    #1;
    check("async_a", led_a, 1'b0);
    check("async_b", led_b, 1'b1);
    check("async_c", led_c, 1'b0);
    repeat (3) @(posedge clk);

    // After the release, the sequence restarts with no carry-over.
    release_reset();
    literal_edges(14);

    // A longer run that only the model checks. It covers several full
    // periods of every instance.
    repeat (100) @(posedge clk);
    @(negedge clk);
    #1 live = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
